// File: rtl/muxn_pipe_if.sv
// Handshake bundle for muxn_pipe: upstream beat (d, s) in, selected beat (y, sel_err) out.
interface muxn_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] d;
  logic [SELW-1:0]    s;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               sel_err;

  // Block side.
  modport slave (
    input  in_valid, d, s, out_ready,
    output in_ready, out_valid, y, sel_err
  );

  // Producer/consumer side.
  modport master (
    output in_valid, d, s, out_ready,
    input  in_ready, out_valid, y, sel_err
  );
endinterface

// File: rtl/muxn_pipe.sv
// N-way WIDTH-bit selector with one registered output stage and a 2-entry skid buffer.
// in_ready comes straight from a flop, so it never depends combinationally on out_ready.
module muxn_pipe #(
  parameter int unsigned  WIDTH = 32,
  parameter int unsigned  N     = 4,
  localparam int unsigned SELW  = $clog2(N)
) (
  input logic        clk,
  input logic        reset,
  muxn_pipe_if.slave bus_io
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] y_q, skid_y_q, mux_y;
  logic             err_q, skid_err_q, mux_err;
  logic             out_valid_q, in_ready_q;
  logic             in_accept, out_xfer;

  // Select d[s]; an index at or beyond N yields zero data with the error flag set.
  always_comb begin
    mux_y   = '0;
    mux_err = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus_io.s == SELW'(i)) begin
        mux_y   = bus_io.d[i*WIDTH +: WIDTH];
        mux_err = 1'b0;
      end
    end
  end

  assign in_accept = bus_io.in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && bus_io.out_ready;

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.y         = y_q;
  assign bus_io.sel_err   = err_q;

  // Occupancy FSM: main register feeds the outputs, skid catches the beat accepted while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      y_q         <= '0;
      err_q       <= 1'b0;
      skid_y_q    <= '0;
      skid_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_accept) begin
            y_q         <= mux_y;
            err_q       <= mux_err;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (in_accept && out_xfer) begin
            y_q   <= mux_y;
            err_q <= mux_err;
          end else if (in_accept) begin
            skid_y_q   <= mux_y;
            skid_err_q <= mux_err;
            in_ready_q <= 1'b0;
            state_q    <= StTwo;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so only the drain of main can happen.
          if (out_xfer) begin
            y_q        <= skid_y_q;
            err_q      <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Protocol properties.
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    out_valid_q && !bus_io.out_ready |=> $stable(y_q) && $stable(err_q) && out_valid_q);

  a_ready_two: assert property (@(posedge clk) disable iff (reset)
    !in_ready_q |-> state_q == StTwo);

  a_first_beat: assert property (@(posedge clk) disable iff (reset)
    in_accept && state_q == StEmpty && !mux_err |=> y_q == $past(mux_y));

  a_err_zero: assert property (@(posedge clk) disable iff (reset)
    err_q |-> y_q == '0);

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench for muxn_pipe: four builds (N/WIDTH = 4/32, 3/32, 2/8, 16/64) driven in
// lockstep from one handshake, each with its own scoreboard queue fed at input acceptance.
module tb_muxn_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] s_raw = '0;
  int         seed = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt4 = 0, cnt3 = 0, cnt2 = 0, cnt16 = 0;

  typedef struct packed {
    logic [63:0] y;
    logic        err;
  } beat_t;

  beat_t q4[$], q3[$], q2[$], q16[$];

  always #5 clk = ~clk;

  muxn_pipe_if #(.WIDTH(32), .N(4))  if4 ();
  muxn_pipe_if #(.WIDTH(32), .N(3))  if3 ();
  muxn_pipe_if #(.WIDTH(8),  .N(2))  if2 ();
  muxn_pipe_if #(.WIDTH(64), .N(16)) if16 ();

  muxn_pipe #(.WIDTH(32), .N(4))  u4  (.clk(clk), .reset(reset), .bus_io(if4.slave));
  muxn_pipe #(.WIDTH(32), .N(3))  u3  (.clk(clk), .reset(reset), .bus_io(if3.slave));
  muxn_pipe #(.WIDTH(8),  .N(2))  u2  (.clk(clk), .reset(reset), .bus_io(if2.slave));
  muxn_pipe #(.WIDTH(64), .N(16)) u16 (.clk(clk), .reset(reset), .bus_io(if16.slave));

  // Data word for input idx of the beat tagged sd; seed 0 gives AAAA.., BBBB.., CCCC.., DDDD..
  function automatic logic [63:0] dval(input int sd, input int idx);
    logic [3:0] nib;
    nib = 4'(sd + 10 + idx);
    return {16{nib}} ^ (64'(sd) << 4);
  endfunction

  function automatic beat_t model(input int n, input int w, input int sel, input int sd);
    beat_t       b;
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sel < n) begin
      b.y   = dval(sd, sel) & m;
      b.err = 1'b0;
    end else begin
      b.y   = '0;
      b.err = 1'b1;
    end
    return b;
  endfunction

  logic [127:0]  d4;
  logic [95:0]   d3;
  logic [15:0]   d2;
  logic [1023:0] d16;

  always_comb begin
    d4  = '0;
    d3  = '0;
    d2  = '0;
    d16 = '0;
    for (int i = 0; i < 4; i++)  d4[i*32 +: 32]  = 32'(dval(seed, i));
    for (int i = 0; i < 3; i++)  d3[i*32 +: 32]  = 32'(dval(seed, i));
    for (int i = 0; i < 2; i++)  d2[i*8 +: 8]    = 8'(dval(seed, i));
    for (int i = 0; i < 16; i++) d16[i*64 +: 64] = dval(seed, i);
  end

  assign if4.in_valid  = in_valid;
  assign if3.in_valid  = in_valid;
  assign if2.in_valid  = in_valid;
  assign if16.in_valid = in_valid;
  assign if4.out_ready  = out_ready;
  assign if3.out_ready  = out_ready;
  assign if2.out_ready  = out_ready;
  assign if16.out_ready = out_ready;
  assign if4.s  = s_raw[1:0];
  assign if3.s  = s_raw[1:0];
  assign if2.s  = s_raw[0];
  assign if16.s = s_raw;
  assign if4.d  = d4;
  assign if3.d  = d3;
  assign if2.d  = d2;
  assign if16.d = d16;

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // Pops and compares every output transfer, then records every accepted input beat.
  task automatic scoreboard();
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        q4.delete();
        q3.delete();
        q2.delete();
        q16.delete();
      end else begin
        if (if4.out_valid && if4.out_ready) begin
          n_checks++;
          if (q4.size() == 0) begin
            n_fail++;
            $display("FAIL sb_n4: got extra beat y=%h err=%b, required none", if4.y, if4.sel_err);
          end else begin
            e = q4.pop_front();
            cnt4++;
            if ({64'(if4.y), if4.sel_err} !== e) begin
              n_fail++;
              $display("FAIL sb_n4: got y=%h err=%b, required y=%h err=%b",
                       if4.y, if4.sel_err, e.y, e.err);
            end
          end
        end
        if (if3.out_valid && if3.out_ready) begin
          n_checks++;
          if (q3.size() == 0) begin
            n_fail++;
            $display("FAIL sb_n3: got extra beat y=%h err=%b, required none", if3.y, if3.sel_err);
          end else begin
            e = q3.pop_front();
            cnt3++;
            if ({64'(if3.y), if3.sel_err} !== e) begin
              n_fail++;
              $display("FAIL sb_n3: got y=%h err=%b, required y=%h err=%b",
                       if3.y, if3.sel_err, e.y, e.err);
            end
          end
        end
        if (if2.out_valid && if2.out_ready) begin
          n_checks++;
          if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL sb_n2: got extra beat y=%h err=%b, required none", if2.y, if2.sel_err);
          end else begin
            e = q2.pop_front();
            cnt2++;
            if ({64'(if2.y), if2.sel_err} !== e) begin
              n_fail++;
              $display("FAIL sb_n2: got y=%h err=%b, required y=%h err=%b",
                       if2.y, if2.sel_err, e.y, e.err);
            end
          end
        end
        if (if16.out_valid && if16.out_ready) begin
          n_checks++;
          if (q16.size() == 0) begin
            n_fail++;
            $display("FAIL sb_n16: got extra beat y=%h err=%b, required none",
                     if16.y, if16.sel_err);
          end else begin
            e = q16.pop_front();
            cnt16++;
            if ({if16.y, if16.sel_err} !== e) begin
              n_fail++;
              $display("FAIL sb_n16: got y=%h err=%b, required y=%h err=%b",
                       if16.y, if16.sel_err, e.y, e.err);
            end
          end
        end
        if (if4.in_valid && if4.in_ready)   q4.push_back(model(4, 32, int'(s_raw[1:0]), seed));
        if (if3.in_valid && if3.in_ready)   q3.push_back(model(3, 32, int'(s_raw[1:0]), seed));
        if (if2.in_valid && if2.in_ready)   q2.push_back(model(2, 8, int'(s_raw[0]), seed));
        if (if16.in_valid && if16.in_ready) q16.push_back(model(16, 64, int'(s_raw), seed));
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;  // must be discarded while reset is high
    s_raw    = 4'd2;
    repeat (3) at_drive();
    reset    = 1'b0;
    in_valid = 1'b0;
    at_sample();
    n_checks++;
    if ({if4.out_valid, if3.out_valid, if2.out_valid, if16.out_valid} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b, required 0000",
               {if4.out_valid, if3.out_valid, if2.out_valid, if16.out_valid});
    end
    n_checks++;
    if ({if4.in_ready, if3.in_ready, if2.in_ready, if16.in_ready} !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1111",
               {if4.in_ready, if3.in_ready, if2.in_ready, if16.in_ready});
    end
    n_checks++;
    if ({if4.y, if4.sel_err, if16.y, if16.sel_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_y: got y4=%h err4=%b y16=%h err16=%b, required all zero",
               if4.y, if4.sel_err, if16.y, if16.sel_err);
    end
  endtask

  task automatic test_single_beat();
    at_drive();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    s_raw     = 4'd2;
    seed      = 0;
    at_drive();
    in_valid = 1'b0;
    at_sample();
    n_checks++;
    if ({if4.out_valid, if4.y, if4.sel_err} !== {1'b1, 32'hCCCC_CCCC, 1'b0}) begin
      n_fail++;
      $display("FAIL single_beat: got valid=%b y=%h err=%b, required valid=1 y=cccccccc err=0",
               if4.out_valid, if4.y, if4.sel_err);
    end
    at_drive();
    at_sample();
    n_checks++;
    if (if4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_beat_idle: got out_valid=%b, required 0", if4.out_valid);
    end
    at_drive();
  endtask

  task automatic test_streaming();
    int c4, c16, c2;
    c4 = cnt4; c16 = cnt16; c2 = cnt2;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        in_valid = 1'b1;
        s_raw    = 4'(k % 4);
        seed     = k + 1;
      end else begin
        in_valid = 1'b0;
      end
      at_sample();
      n_checks++;
      if ({if4.in_ready, if3.in_ready, if2.in_ready, if16.in_ready} !== 4'hF) begin
        n_fail++;
        $display("FAIL stream_in_ready cycle %0d: got %b, required 1111", k,
                 {if4.in_ready, if3.in_ready, if2.in_ready, if16.in_ready});
      end
      if (k >= 1) begin
        n_checks++;
        if ({if4.out_valid, if3.out_valid, if2.out_valid, if16.out_valid} !== 4'hF) begin
          n_fail++;
          $display("FAIL stream_out_valid cycle %0d: got %b, required 1111", k,
                   {if4.out_valid, if3.out_valid, if2.out_valid, if16.out_valid});
        end
      end
      at_drive();
    end
    at_sample();
    n_checks++;
    if (if4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drained: got out_valid=%b, required 0", if4.out_valid);
    end
    at_drive();
    n_checks++;
    if ({cnt4 - c4, cnt2 - c2, cnt16 - c16} !== {32'd8, 32'd8, 32'd8}) begin
      n_fail++;
      $display("FAIL stream_count: got n4=%0d n2=%0d n16=%0d, required 8 each",
               cnt4 - c4, cnt2 - c2, cnt16 - c16);
    end
  endtask

  task automatic test_backpressure();
    int c4, c16, c2;
    bit accepted;
    c4 = cnt4; c16 = cnt16; c2 = cnt2;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s_raw     = 4'd1;
    seed      = 20;
    at_drive();
    s_raw = 4'd2;
    seed  = 21;
    at_sample();
    n_checks++;
    if ({if4.in_ready, if2.in_ready, if16.in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL bp_second_ready: got %b, required 111",
               {if4.in_ready, if2.in_ready, if16.in_ready});
    end
    at_drive();
    s_raw = 4'd3;
    seed  = 22;
    repeat (3) begin
      at_sample();
      n_checks++;
      if ({if4.in_ready, if2.in_ready, if16.in_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL bp_stalled_ready: got %b, required 000",
                 {if4.in_ready, if2.in_ready, if16.in_ready});
      end
      n_checks++;
      if ({if4.out_valid, if4.y, if2.y, if16.y} !==
          {1'b1, 32'(dval(20, 1)), 8'(dval(20, 1)), dval(20, 1)}) begin
        n_fail++;
        $display("FAIL bp_frozen: got v=%b y4=%h y2=%h y16=%h, required v=1 y4=%h y2=%h y16=%h",
                 if4.out_valid, if4.y, if2.y, if16.y,
                 32'(dval(20, 1)), 8'(dval(20, 1)), dval(20, 1));
      end
      at_drive();
    end
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int t = 0; t < 10 && !accepted; t++) begin
      at_sample();
      if (if4.in_ready) accepted = 1'b1;
      at_drive();
    end
    in_valid = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL bp_third_accept: got no accept in 10 cycles, required accept");
    end
    repeat (4) at_drive();
    n_checks++;
    if ({cnt4 - c4, cnt2 - c2, cnt16 - c16} !== {32'd3, 32'd3, 32'd3}) begin
      n_fail++;
      $display("FAIL bp_count: got n4=%0d n2=%0d n16=%0d, required 3 each",
               cnt4 - c4, cnt2 - c2, cnt16 - c16);
    end
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    s_raw     = 4'd3;
    seed      = 40;
    at_drive();
    s_raw = 4'd0;
    seed  = 41;
    at_sample();
    n_checks++;
    if ({if3.out_valid, if3.y, if3.sel_err} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL oor_err: got valid=%b y=%h err=%b, required valid=1 y=0 err=1",
               if3.out_valid, if3.y, if3.sel_err);
    end
    n_checks++;
    if ({if4.y, if4.sel_err} !== {32'(dval(40, 3)), 1'b0}) begin
      n_fail++;
      $display("FAIL oor_n4_inrange: got y=%h err=%b, required y=%h err=0",
               if4.y, if4.sel_err, 32'(dval(40, 3)));
    end
    at_drive();
    in_valid = 1'b0;
    at_sample();
    n_checks++;
    if ({if3.out_valid, if3.y, if3.sel_err} !== {1'b1, 32'(dval(41, 0)), 1'b0}) begin
      n_fail++;
      $display("FAIL oor_recover: got valid=%b y=%h err=%b, required valid=1 y=%h err=0",
               if3.out_valid, if3.y, if3.sel_err, 32'(dval(41, 0)));
    end
    repeat (2) at_drive();
  endtask

  task automatic test_reset_mid();
    int c4, c16;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s_raw     = 4'd0;
    seed      = 50;
    at_drive();
    s_raw = 4'd2;
    seed  = 51;
    at_drive();
    reset = 1'b1;
    s_raw = 4'd3;
    seed  = 52;
    at_sample();
    n_checks++;
    if ({if4.in_ready, if16.in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_full: got in_ready=%b, required 00", {if4.in_ready, if16.in_ready});
    end
    at_drive();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c4  = cnt4;
    c16 = cnt16;
    at_sample();
    n_checks++;
    if ({if4.out_valid, if4.in_ready, if4.y, if4.sel_err, if16.out_valid, if16.in_ready}
        !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_flush: got v4=%b r4=%b y4=%h e4=%b v16=%b r16=%b, required 0 1 0 0 0 1",
               if4.out_valid, if4.in_ready, if4.y, if4.sel_err, if16.out_valid, if16.in_ready);
    end
    at_drive();
    in_valid = 1'b1;
    s_raw    = 4'd1;
    seed     = 53;
    at_drive();
    in_valid = 1'b0;
    repeat (3) at_drive();
    n_checks++;
    if ({cnt4 - c4, cnt16 - c16} !== {32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL mid_count: got n4=%0d n16=%0d, required 1 each", cnt4 - c4, cnt16 - c16);
    end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    n_checks++;
    if (q4.size() + q3.size() + q2.size() + q16.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d queued beats, required 0",
               q4.size() + q3.size() + q2.size() + q16.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
